// File: rtl/seq_pkg.sv
// Shared encodings for the multi-cycle RV32 sequencer: FSM states, one-hot
// instruction-class bit positions, PC source selects and a one-hot checker.
package seq_pkg;

  typedef logic [2:0] state_e;
  localparam state_e IDLE   = 3'd0;
  localparam state_e FETCH  = 3'd1;
  localparam state_e DECODE = 3'd2;
  localparam state_e EXEC   = 3'd3;
  localparam state_e MEM    = 3'd4;
  localparam state_e WB     = 3'd5;
  localparam state_e FAULT  = 3'd6;

  localparam int IT_R   = 0;
  localparam int IT_I   = 1;
  localparam int IT_L   = 2;
  localparam int IT_S   = 3;
  localparam int IT_B   = 4;
  localparam int IT_J   = 5;
  localparam int IT_JR  = 6;
  localparam int IT_LUI = 7;
  localparam int IT_AUI = 8;

  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_BR   = 2'b01;
  localparam logic [1:0] PC_SEL_JALR = 2'b11;

  function automatic logic is_onehot(input logic [8:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 9; i++) n += int'(v[i]);
    return (n == 1);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles; expired flags the last allowed wait
// cycle so the FSM can fault if ready does not arrive in it.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [TW-1:0] LAST = TW'(MEM_TIMEOUT - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) cnt <= '0;
    else if (en)       cnt <= cnt + TW'(1);
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the RV32 datapath: one instruction at a time,
// req/ready memory handshake with wait-state timeout and a sticky fault state.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic [8:0]       inst_type,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             busy,
  output logic             fault,
  output logic             illegal,
  output logic [CNT_W-1:0] retire_cnt
);

  state_e     state, state_nx;
  logic [8:0] it_q;
  logic       retire, mem_wait, tmr_exp;

  // Timer runs only while a request is stalled, so it is zero on every entry.
  assign mem_wait = (imem_req | dmem_req) & ~mem_ready;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (~mem_wait),
    .en      (mem_wait),
    .expired (tmr_exp)
  );

  always_comb begin
    imem_req   = (state == FETCH);
    ir_write   = imem_req & mem_ready;
    dmem_req   = (state == MEM);
    dmem_we    = dmem_req & it_q[IT_S];
    reg_write  = (state == WB);
    mem_to_reg = reg_write & it_q[IT_L];
    pc_write   = 1'b0;
    pc_sel     = PC_SEL_SEQ;
    case (state)
      EXEC: if (it_q[IT_B]) begin
        pc_write = 1'b1;
        pc_sel   = branch_taken ? PC_SEL_BR : PC_SEL_SEQ;
      end
      MEM: if (it_q[IT_S] && mem_ready) pc_write = 1'b1;
      WB: begin
        pc_write = 1'b1;
        if (it_q[IT_J])       pc_sel = PC_SEL_BR;
        else if (it_q[IT_JR]) pc_sel = PC_SEL_JALR;
      end
      default: ;
    endcase
    // Every instruction retires in exactly the cycle it commits its PC.
    retire = pc_write;
    busy   = (state != IDLE) && (state != FAULT);
    fault  = (state == FAULT);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = FETCH;
      FETCH:  if (mem_ready) state_nx = DECODE;
              else if (tmr_exp) state_nx = FAULT;
      DECODE: state_nx = is_onehot(inst_type) ? EXEC : FAULT;
      EXEC:   if (it_q[IT_L] || it_q[IT_S]) state_nx = MEM;
              else if (it_q[IT_B]) state_nx = halt ? IDLE : FETCH;
              else state_nx = WB;
      MEM:    if (mem_ready) state_nx = it_q[IT_L] ? WB : (halt ? IDLE : FETCH);
              else if (tmr_exp) state_nx = FAULT;
      WB:     state_nx = halt ? IDLE : FETCH;
      FAULT:  state_nx = FAULT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      it_q       <= '0;
      illegal    <= 1'b0;
      retire_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == DECODE) it_q <= inst_type;
      if (state == DECODE && !is_onehot(inst_type)) illegal <= 1'b1;
      if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed plus randomized instruction streams against a per-instruction
// timing model built from the class latencies and handshake rules.
module tb_multicycle_sequencer;

  localparam int TMO = 4;
  localparam int CW  = 4;

  localparam logic [15:0] IMEM = 16'h0800;
  localparam logic [15:0] IRW  = 16'h0400;
  localparam logic [15:0] DREQ = 16'h0200;
  localparam logic [15:0] DWE  = 16'h0100;
  localparam logic [15:0] RW   = 16'h0080;
  localparam logic [15:0] M2R  = 16'h0040;
  localparam logic [15:0] PCW  = 16'h0020;
  localparam logic [15:0] BUSY = 16'h0004;
  localparam logic [15:0] FLT  = 16'h0002;
  localparam logic [15:0] ILL  = 16'h0001;
  localparam logic [15:0] NONE = 16'h0000;

  logic          clk = 1'b0;
  logic          rst_n, start, halt, branch_taken, mem_ready;
  logic [8:0]    inst_type;
  logic          imem_req, ir_write, dmem_req, dmem_we, reg_write, mem_to_reg, pc_write;
  logic [1:0]    pc_sel;
  logic          busy, fault, illegal;
  logic [CW-1:0] retire_cnt;

  int vectors    = 0;
  int miscompares = 0;
  int model_cnt  = 0;
  bit halted;

  multicycle_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .inst_type(inst_type),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .imem_req(imem_req),
    .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .pc_write(pc_write), .pc_sel(pc_sel), .busy(busy),
    .fault(fault), .illegal(illegal), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  wire [15:0] obs = {4'b0, imem_req, ir_write, dmem_req, dmem_we, reg_write,
                     mem_to_reg, pc_write, pc_sel, busy, fault, illegal};

  function automatic logic [15:0] psel(input int v);
    return 16'(v) << 3;
  endfunction

  task automatic check(input string tag, input logic [15:0] o, input logic [15:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One clock: check outputs mid-cycle, then advance and update the model.
  task automatic step(input string tag, input logic [15:0] e, input bit ret);
    @(negedge clk);
    check(tag, obs, e);
    check({tag, "_cnt"}, 16'(retire_cnt), 16'(model_cnt));
    @(posedge clk);
    #1;
    if (!rst_n) model_cnt = 0;
    else if (ret) model_cnt = (model_cnt + 1) % (1 << CW);
  endtask

  task automatic kick();
    start = 1'b1;
    step("idle_start", NONE, 0);
    start = 1'b0;
  endtask

  task automatic do_reset(input string tag, input logic [15:0] e);
    rst_n = 1'b0;
    start = 1'b0;
    mem_ready = 1'b0;
    step(tag, e, 0);
    rst_n = 1'b1;
    step("post_reset", NONE, 0);
  endtask

  // t: class bit index, fw/mw: wait cycles before ready, tk: branch_taken, hl: halt at retire.
  task automatic do_instr(input int t, input int fw, input int mw, input bit tk, input bit hl);
    logic ld, st, br;
    ld = (t == 2);
    st = (t == 3);
    br = (t == 4);
    for (int k = 0; k <= fw; k++) begin
      mem_ready = (k == fw);
      inst_type = 9'($urandom);
      start = 1'($urandom);
      halt = 1'($urandom);
      branch_taken = 1'($urandom);
      step("fetch", IMEM | ((k == fw) ? IRW : NONE) | BUSY, 0);
    end
    inst_type = 9'(1) << t;
    mem_ready = 1'($urandom);
    step("decode", BUSY, 0);
    inst_type = 9'($urandom);
    branch_taken = tk;
    halt = br ? hl : 1'($urandom);
    if (br) step("exec_b", PCW | psel(tk ? 1 : 0) | BUSY, 1);
    else    step("exec", BUSY, 0);
    if (ld || st) begin
      for (int k = 0; k <= mw; k++) begin
        mem_ready = (k == mw);
        halt = (st && k == mw) ? hl : 1'($urandom);
        step("mem", DREQ | (st ? DWE : NONE) | ((st && k == mw) ? PCW : NONE) | BUSY,
             st && (k == mw));
      end
    end
    if (!br && !st) begin
      mem_ready = 1'($urandom);
      halt = hl;
      step("wb", RW | (ld ? M2R : NONE) | PCW | psel(t == 5 ? 1 : (t == 6 ? 3 : 0)) | BUSY, 1);
    end
    halt = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    logic [8:0] bad [3];
    bad[0] = 9'h003; bad[1] = 9'h000; bad[2] = 9'h1FF;
    rst_n = 1'b0; start = 1'b0; halt = 1'b0; inst_type = '0;
    branch_taken = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    halt = 1'b1; mem_ready = 1'b1; inst_type = 9'h1FF;
    step("reset_state", NONE, 0);
    rst_n = 1'b1;
    step("idle_hold", NONE, 0);

    // Directed: R, load with 3 data waits, taken/not-taken branch, J then Jr with halt.
    kick();
    do_instr(0, 0, 0, 0, 0);
    do_instr(2, 0, 3, 0, 0);
    do_instr(4, 0, 0, 1, 0);
    do_instr(4, 0, 0, 0, 0);
    do_instr(5, 0, 0, 0, 0);
    do_instr(6, 0, 0, 0, 1);
    step("halted_idle", NONE, 0);

    // Ready on the last allowed fetch wait cycle and data wait cycle.
    kick();
    do_instr(1, TMO - 1, 0, 0, 0);
    do_instr(3, 0, TMO - 1, 0, 1);

    // Random instruction stream; wraps the retire counter.
    halted = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int t;
      bit hl;
      if (halted) kick();
      t  = $urandom_range(0, 8);
      hl = ($urandom_range(0, 7) == 0);
      do_instr(t, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), hl);
      halted = hl;
    end
    if (!halted) begin
      do_instr(0, 0, 0, 0, 1);
    end

    // Illegal decodes fault sticky; start ignored until reset.
    for (int b = 0; b < 3; b++) begin
      kick();
      mem_ready = 1'b1;
      step("ill_fetch", IMEM | IRW | BUSY, 0);
      inst_type = bad[b];
      step("ill_decode", BUSY, 0);
      for (int k = 0; k < 3; k++) begin
        start = 1'b1;
        step("ill_fault", FLT | ILL, 0);
      end
      do_reset("ill_reset", FLT | ILL);
    end

    // Fetch never ready: fault after TMO request cycles.
    kick();
    mem_ready = 1'b0;
    for (int k = 0; k < TMO; k++) step("tmo_fetch", IMEM | BUSY, 0);
    start = 1'b1;
    step("tmo_fetch_fault", FLT, 0);
    do_reset("tmo_fetch_reset", FLT);

    // Data never ready: fault after TMO request cycles.
    kick();
    mem_ready = 1'b1;
    step("tmo_m_fetch", IMEM | IRW | BUSY, 0);
    inst_type = 9'(1) << 2;
    step("tmo_m_decode", BUSY, 0);
    mem_ready = 1'b0;
    step("tmo_m_exec", BUSY, 0);
    for (int k = 0; k < TMO; k++) step("tmo_mem", DREQ | BUSY, 0);
    step("tmo_mem_fault", FLT, 0);
    do_reset("tmo_mem_reset", FLT);

    // Reset in the middle of a stalled store.
    kick();
    do_instr(0, 0, 0, 0, 0);
    mem_ready = 1'b1;
    step("rst_fetch", IMEM | IRW | BUSY, 0);
    inst_type = 9'(1) << 3;
    step("rst_decode", BUSY, 0);
    mem_ready = 1'b0;
    step("rst_exec", BUSY, 0);
    step("rst_mem", DREQ | DWE | BUSY, 0);
    do_reset("rst_mid_mem", DREQ | DWE | BUSY);
    step("rst_idle", NONE, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
